fir_mac_sequencer: RTL
======================

// Module: fir_mac_sequencer
// PURPOSE
// - Controls a time-multiplexed single-MAC FIR filter. Each input sample is written into an external
//   circular sample RAM. The block then steps through the TAPS sample and coefficient addresses,
//   drives the MAC clear/enable strobes and returns one scaled output per input sample.
// - Position in the chain: UART RX sample stream -> this block (+ sample RAM, coef ROM, MAC) -> FFT input.
// PARAMETERS
// - DATA_W   16  sample and output width, two's complement
// - TAPS     16  number of filter taps, 2..2^AW
// - AW        4  address width for the sample RAM and coefficient ROM
// - ACC_W    40  MAC accumulator width, signed
// - SHIFT    15  right arithmetic shift applied to the accumulator before output
// - RD_LAT    1  sample RAM / coef ROM read latency, cycles (1..3)
// - MAC_LAT   2  cycles from a mac_en beat to that product appearing in mac_acc (1..4)
// PORTS
// - clk          in   1       system clock
// - rst          in   1       asynchronous, active-high reset
// - in_valid     in   1       input sample valid
// - in_ready     out  1       block can accept a sample
// - in_data      in   DATA_W  input sample
// - smp_wr_en    out  1       sample RAM write strobe
// - smp_wr_addr  out  AW      sample RAM write address
// - smp_wr_data  out  DATA_W  sample RAM write data
// - smp_rd_addr  out  AW      sample RAM read address
// - coef_addr    out  AW      coefficient ROM read address
// - mac_clr      out  1       clear the accumulator (single-cycle pulse)
// - mac_en       out  1       accumulate the current product
// - mac_acc      in   ACC_W   accumulator value from the MAC
// - out_valid    out  1       output sample valid
// - out_ready    in   1       downstream accepts the output
// - out_data     out  DATA_W  scaled filter output
// - out_sat      out  1       the current out_data was clamped
// - busy         out  1       FSM is in any state other than IDLE
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - all outputs 0; wr_ptr=0; FSM enters INIT.
//   - If reset is asserted mid-operation, the operation is aborted. No out_valid is produced for that sample.
// - INIT: TAPS cycles writing 0 to addresses 0..TAPS-1.
//   - smp_wr_en=1, in_ready=0, busy=1. Then go to IDLE.
// - IDLE: in_ready=1, busy=0.
//   - On in_valid&&in_ready (cycle 0): smp_wr_en=1, smp_wr_addr=wr_ptr, smp_wr_data=in_data.
//   - Same cycle: mac_clr=1. Latch cur=wr_ptr; wr_ptr advances (TAPS-1 wraps to 0). Go to RUN.
// - RUN (cycles 1..TAPS, k=0..TAPS-1):
//   - coef_addr=k; smp_rd_addr=(cur-k) mod TAPS, with explicit wrap so non-power-of-2 TAPS works.
//   - in_ready=0.
// - mac_en = the RUN address-valid signal delayed by RD_LAT. It is high for exactly TAPS consecutive cycles.
// - DRAIN: wait until MAC_LAT cycles after the last mac_en beat.
//   - Capture y=mac_acc>>>SHIFT into out_data, truncated to DATA_W. Go to OUT.
// - OUT: out_valid=1; out_data and out_sat stay stable until out_ready.
//   - On the handshake cycle, go to IDLE. in_ready rises the next cycle; there is no combinational ready path.
// - Latency: accept at cycle 0 -> out_valid first high at cycle TAPS+RD_LAT+MAC_LAT+1 (20 with defaults).
// - Throughput: one sample per TAPS+RD_LAT+MAC_LAT+2 cycles minimum. Samples presented while busy wait (in_ready=0).
// - in_valid is ignored in INIT/RUN/DRAIN/OUT; no sample is lost or duplicated.
// - smp_wr_en never coincides with RUN reads.
// - Idle values of smp_rd_addr/coef_addr: hold their last value.
// CONFIGURATION
// - SATURATE_FIR_OUT_EN defined:
//   - the shifted accumulator is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//   - out_sat=1 when clamping occurred.
// - Not defined: plain truncation to the low DATA_W bits of the shifted accumulator; out_sat tied 0.
// TESTING
// - Reset then release -> smp_wr_en high 16 cycles, addr 0..15, data 0, in_ready=0; in_ready=1 at the 17th cycle.
// - SHIFT=0, coef h[k]=k+1, bench MAC model; inputs 1 then 16x 0 -> outputs 1,2,..,16,0.
// - Accept at cycle T -> out_valid at T+20; rd_addr sequence cur,cur-1,..,cur-15 mod 16; mac_en 16 beats at T+2..T+17.
// - 17th sample after INIT -> written to addr 0; reads 0,15,14,..,1.
// - out_ready held 0 for 10 cycles -> out_valid/out_data stable, in_ready=0, no mac_en; release -> in_ready at +1.
// - mac_acc=2^38 with SATURATE_FIR_OUT_EN -> out_data=0x7FFF, out_sat=1; without -> out_data=acc[30:15], out_sat=0.
// - rst pulsed at RUN k=5 -> outputs 0 immediately, INIT reruns, no out_valid for the aborted sample.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Address/strobe sequencer for a time-multiplexed single-MAC FIR filter.
// Writes each accepted sample into a circular sample RAM, walks TAPS
// sample/coefficient address pairs, strobes the external MAC and returns
// one scaled output per input sample.
// Optional build macro: SATURATE_FIR_OUT_EN (clamp output instead of truncating).
module fir_mac_sequencer #(
  parameter int DATA_W  = 16,
  parameter int TAPS    = 16,
  parameter int AW      = 4,
  parameter int ACC_W   = 40,
  parameter int SHIFT   = 15,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              smp_wr_en,
  output logic [AW-1:0]     smp_wr_addr,
  output logic [DATA_W-1:0] smp_wr_data,
  output logic [AW-1:0]     smp_rd_addr,
  output logic [AW-1:0]     coef_addr,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int DRAIN_LEN = RD_LAT + MAC_LAT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t              state, state_nx;
  logic [AW-1:0]       init_cnt;
  logic [AW-1:0]       wr_ptr;
  logic [2:0]          drain_cnt;
  logic [RD_LAT-1:0]   vld_sr;
  logic                accept;
  logic                run_v;
  logic                drain_last;
  logic signed [ACC_W-1:0] shifted;
  logic [DATA_W-1:0]   y_data;
  logic                y_sat;

  assign run_v      = (state == S_RUN);
  assign drain_last = (state == S_DRAIN) && (drain_cnt == 3'(DRAIN_LEN - 1));
  assign mac_en     = vld_sr[RD_LAT-1];
  assign shifted    = $signed(mac_acc) >>> SHIFT;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  // Next-state decode and state-derived strobes
  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    smp_wr_en   = 1'b0;
    smp_wr_addr = wr_ptr;
    smp_wr_data = '0;
    mac_clr     = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    unique case (state)
      S_INIT: begin
        smp_wr_en   = 1'b1;
        smp_wr_addr = init_cnt;
        if (init_cnt == LAST_ADDR) state_nx = S_IDLE;
      end
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept      = 1'b1;
          smp_wr_en   = 1'b1;
          smp_wr_data = in_data;
          mac_clr     = 1'b1;
          state_nx    = S_RUN;
        end
      end
      S_RUN:   if (coef_addr == LAST_ADDR) state_nx = S_DRAIN;
      S_DRAIN: if (drain_last) state_nx = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_INIT;
    endcase
    // The FSM sits in INIT while reset is held; keep the strobes quiet until release.
    if (rst) begin
      smp_wr_en = 1'b0;
      busy      = 1'b0;
    end
  end

  // Pointers, address walk, MAC enable pipeline and output capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt    <= '0;
      wr_ptr      <= '0;
      coef_addr   <= '0;
      smp_rd_addr <= '0;
      drain_cnt   <= '0;
      vld_sr      <= '0;
      out_data    <= '0;
      out_sat     <= 1'b0;
    end else begin
      if (state == S_INIT) init_cnt <= (init_cnt == LAST_ADDR) ? '0 : init_cnt + AW'(1);
      if (accept) begin
        wr_ptr      <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
        coef_addr   <= '0;
        smp_rd_addr <= wr_ptr;
      end else if (run_v && (coef_addr != LAST_ADDR)) begin
        coef_addr   <= coef_addr + AW'(1);
        smp_rd_addr <= (smp_rd_addr == '0) ? LAST_ADDR : smp_rd_addr - AW'(1);
      end
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      vld_sr    <= RD_LAT'({vld_sr, run_v});
      if (drain_last) begin
        out_data <= y_data;
        out_sat  <= y_sat;
      end
    end
  end

`ifdef SATURATE_FIR_OUT_EN
  // Clamp the shifted accumulator into the signed output range
  always_comb begin
    y_data = shifted[DATA_W-1:0];
    y_sat  = 1'b0;
    if (shifted > SAT_MAX) begin
      y_data = SAT_MAX[DATA_W-1:0];
      y_sat  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      y_data = SAT_MIN[DATA_W-1:0];
      y_sat  = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign y_data    = shifted[DATA_W-1:0];
  assign y_sat     = 1'b0;
  assign unused_hi = ^{shifted[ACC_W-1:DATA_W], SAT_MAX, SAT_MIN};
`endif

endmodule
